// File: rtl/bringup_pkg.sv
// Shared definitions for the bringup UART beacon: frame FSM states, line levels
// and the per-channel identification byte.
package bringup_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } beacon_state_e;

  localparam int unsigned FRAME_BITS     = 10;
  localparam logic        UART_IDLE      = 1'b1;
  localparam logic        LVL_DIR_OUTPUT = 1'b1;

  // Identification byte of a channel; the 8-bit wrap is intentional.
  function automatic logic [7:0] channel_code(input logic [7:0]  base,
                                              input logic [7:0]  step,
                                              input int unsigned ch);
    logic [31:0] sum;
    sum = 32'(base) + 32'(step) * ch;
    return sum[7:0];
  endfunction

endpackage

// File: rtl/beacon_tick.sv
// Enable-gated periodic tick: one-cycle pulse every CLOCKS_PER_PULSE enabled
// cycles, counter held at zero while disabled.
module beacon_tick
  import bringup_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 120000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned          CNT_W = $clog2(CLOCKS_PER_PULSE);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(CLOCKS_PER_PULSE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bringup_uart_beacon.sv
// Multi-channel 8N1 beacon: one shared baud/bit engine drives every tx pin,
// each active pin carrying its own identification byte.
module bringup_uart_beacon
  import bringup_pkg::*;
#(
  parameter int unsigned CHANNELS         = 16,
  parameter int unsigned CLOCKS_PER_BAUD  = 104,
  parameter int unsigned CLOCKS_PER_PULSE = 120000,
  parameter logic [7:0]  CODE_BASE        = 8'h45,
  parameter logic [7:0]  CODE_STEP        = 8'h04
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                mode,
  input  logic                trigger,
  output logic [CHANNELS-1:0] tx,
  output logic                busy,
  output logic [5:0]          cur_channel,
  output logic [15:0]         frame_count,
  output logic [7:0]          overrun_count
);

  localparam int unsigned       BAUD_W    = $clog2(CLOCKS_PER_BAUD);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [6:0]        CH_COUNT  = 7'(CHANNELS);

  beacon_state_e       state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] tx_q, tx_d;
  logic                mode_q, mode_d;
  logic                busy_q, busy_d;
  logic [5:0]          cur_q, cur_d;
  logic [15:0]         frames_q, frames_d;
  logic [7:0]          ovr_q, ovr_d;
  logic                tick, start_req, baud_end;
  logic [6:0]          cur_inc;

  beacon_tick #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
  ) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick)
  );

  assign start_req = enable & (tick | trigger);
  assign baud_end  = (baud_q == BAUD_LAST);
  assign cur_inc   = {1'b0, cur_q} + 7'd1;

  always_comb begin : fsm
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    cur_d    = cur_q;
    frames_d = frames_q;
    ovr_d    = ovr_q;

    if (busy_q && start_req && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_START;
          baud_d  = '0;
          mode_d  = mode;
          busy_d  = 1'b1;
          for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            mask_d[ch] = !mode || (cur_q == 6'(ch));
          end
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          state_d  = ST_IDLE;
          baud_d   = '0;
          busy_d   = 1'b0;
          frames_d = frames_q + 16'd1;
          if (mode_q) cur_d = (cur_inc == CH_COUNT) ? 6'd0 : cur_inc[5:0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line levels derive from the next-state values so tx is a plain register
  // that changes on the same edge as the FSM.
  always_comb begin : line_drive
    logic [7:0] code;
    code = '0;
    tx_d = {CHANNELS{UART_IDLE}};
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      code = channel_code(CODE_BASE, CODE_STEP, ch);
      if (mask_d[ch]) begin
        unique case (state_d)
          ST_START: tx_d[ch] = 1'b0;
          ST_DATA:  tx_d[ch] = code[bit_d];
          default:  tx_d[ch] = UART_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      mask_q   <= '0;
      tx_q     <= {CHANNELS{UART_IDLE}};
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      cur_q    <= '0;
      frames_q <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      mask_q   <= mask_d;
      tx_q     <= tx_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      cur_q    <= cur_d;
      frames_q <= frames_d;
      ovr_q    <= ovr_d;
    end
  end

  assign tx            = tx_q;
  assign busy          = busy_q;
  assign cur_channel   = cur_q;
  assign frame_count   = frames_q;
  assign overrun_count = ovr_q;

endmodule
